// File: rtl/mx_conv_pkg.sv
// mx_conv_pkg: shared types and constants for the mx_conv_arb front end.
//   arb_state_t  - arbiter FSM state (IDLE / LOCKED)
//   BF16_BIAS    - bf16 exponent bias
//   BF16_FRAC_W  - bf16 stored fraction width
//   rr_next()    - round-robin successor index modulo n
package mx_conv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned BF16_BIAS   = 127;
  localparam int unsigned BF16_FRAC_W = 7;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mx_conv_fx2bf16.sv
// mx_conv_fx2bf16: combinational two's-complement fixed-point to bf16.
//   fx_i   - signed integer input, BW bits
//   bf16_o - bf16 result, round-to-nearest-even on the 7-bit fraction
module mx_conv_fx2bf16
  import mx_conv_pkg::*;
#(
  parameter int unsigned BW = 16
) (
  input  logic [BW-1:0] fx_i,
  output logic [15:0]   bf16_o
);

  localparam int unsigned MSB_W = $clog2(BW);

  logic              sign;
  logic [BW-1:0]     mag;
  logic [MSB_W-1:0]  msb;
  logic [BW-1:0]     norm;
  logic [BW:0]       ext;
  logic [6:0]        frac;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [7:0]        frac_r;
  logic [7:0]        expo;

  always_comb begin
    sign = fx_i[BW-1];
    // Unsigned at BW bits, so the most-negative input maps to 2^(BW-1).
    mag  = sign ? (~fx_i + BW'(1)) : fx_i;
    msb  = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      if (mag[i]) msb = MSB_W'(i);
    end
    norm   = mag << (MSB_W'(BW - 1) - msb);
    // Hidden one dropped; two zero bits appended so guard/sticky exist at BW=9.
    ext    = {norm[BW-2:0], 2'b00};
    frac   = ext[BW -: BF16_FRAC_W];
    guard  = ext[BW-7];
    sticky = |ext[BW-8:0];
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + 8'(rnd);
    expo   = 8'(msb) + 8'(BF16_BIAS) + 8'(frac_r[7]);
    bf16_o = (mag == '0) ? '0 : {sign, expo, frac_r[6:0]};
  end

endmodule

// File: rtl/rr_arb_n.sv
// rr_arb_n: masked round-robin priority pick.
//   req_i  - request vector
//   ptr_i  - index searched first
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - index of the granted requester
//   any_o  - at least one request present
module rr_arb_n
  import mx_conv_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned k;
      k = (32'(ptr_i) + off) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mx_conv_arb.sv
// mx_conv_arb: block-granular round-robin arbiter sharing one fixed-to-bf16
// converter among N_REQ requesters, with a single registered output stage.
//   i_clk, i_rst                - clock, synchronous active-high reset
//   i_req_valid/data/tag/last   - per-requester element stream
//   o_req_ready                 - per-requester accept (one-hot or zero)
//   o_bf16_valid/data/src/tag/last, i_bf16_ready - result stream
//   o_blk_cnt                   - per-requester completed-block counters,
//                                 present only with MX_CONV_ARB_STATS_EN
module mx_conv_arb
  import mx_conv_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*BIT_WIDTH-1:0] i_req_data,
  input  logic [N_REQ*TAG_W-1:0]     i_req_tag,
  input  logic [N_REQ-1:0]           i_req_last,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_bf16_valid,
  output logic [15:0]                o_bf16_data,
  output logic [$clog2(N_REQ)-1:0]   o_bf16_src,
  output logic [TAG_W-1:0]           o_bf16_tag,
  output logic                       o_bf16_last,
  input  logic                       i_bf16_ready
`ifdef MX_CONV_ARB_STATS_EN
  ,output logic [N_REQ*16-1:0]       o_blk_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             valid_q;
  logic [15:0]      data_q;
  logic [IDX_W-1:0] src_q;
  logic [TAG_W-1:0] tag_q;
  logic             last_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic             can_load;
  logic [N_REQ-1:0] ready;
  logic [IDX_W-1:0] sel_idx;
  logic             xfer;
  logic [BIT_WIDTH-1:0] sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_last;
  logic [15:0]      conv;

  rr_arb_n #(.N(N_REQ), .IW(IDX_W)) u_arb (
    .req_i (i_req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  mx_conv_fx2bf16 #(.BW(BIT_WIDTH)) u_conv (
    .fx_i   (sel_data),
    .bf16_o (conv)
  );

  always_comb begin
    can_load = !valid_q || i_bf16_ready;
    sel_idx  = (state_q == LOCKED) ? owner_q : arb_idx;
    ready    = '0;
    if (can_load) begin
      // A locked owner is offered ready even while it has no valid element.
      if (state_q == LOCKED) ready[owner_q] = 1'b1;
      else if (arb_any)      ready = arb_gnt;
    end
    xfer     = |(i_req_valid & ready);
    sel_data = i_req_data[sel_idx*BIT_WIDTH +: BIT_WIDTH];
    sel_tag  = i_req_tag[sel_idx*TAG_W +: TAG_W];
    sel_last = i_req_last[sel_idx];

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (xfer) begin
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = IDX_W'(rr_next(32'(sel_idx), N_REQ));
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = sel_idx;
      end
    end
  end

  assign o_req_ready = ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      tag_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      if (can_load) begin
        valid_q <= xfer;
        if (xfer) begin
          data_q <= conv;
          src_q  <= sel_idx;
          tag_q  <= sel_tag;
          last_q <= sel_last;
        end
      end
    end
  end

  assign o_bf16_valid = valid_q;
  assign o_bf16_data  = data_q;
  assign o_bf16_src   = src_q;
  assign o_bf16_tag   = tag_q;
  assign o_bf16_last  = last_q;

`ifdef MX_CONV_ARB_STATS_EN
  logic [15:0] blk_cnt_q [N_REQ];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < N_REQ; k++) blk_cnt_q[k] <= '0;
    end else if (xfer && sel_last && (blk_cnt_q[sel_idx] != '1)) begin
      blk_cnt_q[sel_idx] <= blk_cnt_q[sel_idx] + 16'd1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) o_blk_cnt[k*16 +: 16] = blk_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_mx_conv_arb.sv
// tb_mx_conv_arb: self-checking bench for mx_conv_arb (N_REQ=4, 16-bit input).
// A behavioural model (arithmetic bf16 rounding, round-robin search from a
// pointer, block lock) is compared against the DUT every cycle; directed
// phases add literal expectations; a long randomized phase follows.
module tb_mx_conv_arb;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    vld = '0;
  logic [N*BW-1:0] dat = '0;
  logic [N*TW-1:0] tag = '0;
  logic [N-1:0]    lst = '0;
  logic            rdy = 1'b1;
  logic [N-1:0]    o_req_ready;
  logic            o_bf16_valid;
  logic [15:0]     o_bf16_data;
  logic [1:0]      o_bf16_src;
  logic [TW-1:0]   o_bf16_tag;
  logic            o_bf16_last;
`ifdef MX_CONV_ARB_STATS_EN
  logic [N*16-1:0] o_blk_cnt;
`endif

  always #5 clk = ~clk;

  mx_conv_arb #(.N_REQ(N), .BIT_WIDTH(BW), .TAG_W(TW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (vld),
    .i_req_data   (dat),
    .i_req_tag    (tag),
    .i_req_last   (lst),
    .o_req_ready  (o_req_ready),
    .o_bf16_valid (o_bf16_valid),
    .o_bf16_data  (o_bf16_data),
    .o_bf16_src   (o_bf16_src),
    .o_bf16_tag   (o_bf16_tag),
    .o_bf16_last  (o_bf16_last),
    .i_bf16_ready (rdy)
`ifdef MX_CONV_ARB_STATS_EN
    ,.o_blk_cnt   (o_blk_cnt)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic logic [15:0] ref_bf16(input logic [BW-1:0] x);
    longint v, m, q, rem, half;
    int p, sh;
    bit s;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 16'h0000;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 7) q = m << (7 - p);
    else begin
      sh   = p - 7;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 256) begin q = 128; p++; end
    end
    return {s, 8'(p + 127), 7'(q - 128)};
  endfunction

  // Behavioural model state.
  bit           m_locked;
  int           m_owner, m_ptr;
  bit           m_v;
  logic [15:0]  m_data;
  int           m_src;
  logic [TW-1:0] m_tag;
  bit           m_last;
  logic [N-1:0] m_acc;
  int           m_cnt [N];

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!m_v || rdy) begin
      if (m_locked) r[m_owner] = 1'b1;
      else begin
        for (int off = 0; off < N; off++) begin
          int k;
          k = (m_ptr + off) % N;
          if (vld[k]) begin r[k] = 1'b1; break; end
        end
      end
    end
    return r;
  endfunction

  task automatic model_update();
    logic [N-1:0] acc;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_v = 0;
      m_data = '0; m_src = 0; m_tag = '0; m_last = 0; m_acc = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      return;
    end
    acc = exp_ready() & vld;
    m_acc = acc;
    if (!m_v || rdy) m_v = (acc != '0);
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        m_data = ref_bf16(dat[k*BW +: BW]);
        m_src  = k;
        m_tag  = tag[k*TW +: TW];
        m_last = lst[k];
        if (lst[k]) begin
          m_locked = 0;
          m_ptr    = (k + 1) % N;
          if (m_cnt[k] < 16'hFFFF) m_cnt[k]++;
        end else begin
          m_locked = 1;
          m_owner  = k;
        end
      end
    end
  endtask

  // Requester stimulus generators.
  bit            g_auto = 0;
  bit [N-1:0]    g_en = '0;
  int            g_prob = 100;
  int            g_fixlen = 1;
  bit            g_v [N];
  logic [BW-1:0] g_d [N];
  logic [TW-1:0] g_t [N];
  bit            g_l [N];
  int            g_pos [N];
  int            g_len [N];

  function automatic int pick_len();
    return (g_fixlen > 0) ? g_fixlen : int'($urandom_range(1, 4));
  endfunction

  function automatic logic [BW-1:0] pick_data();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return BW'($urandom_range(0, 600));
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic gen_reset();
    for (int k = 0; k < N; k++) begin
      g_v[k] = 0; g_l[k] = 0; g_pos[k] = 0; g_len[k] = pick_len();
      g_d[k] = '0; g_t[k] = '0;
    end
  endtask

  task automatic gen_update();
    for (int k = 0; k < N; k++) begin
      if (m_acc[k]) begin
        if (g_l[k]) begin g_pos[k] = 0; g_len[k] = pick_len(); end
        else g_pos[k]++;
        g_v[k] = 0;
      end
      if (!g_v[k] && g_en[k] && ($urandom % 100 < g_prob)) begin
        g_v[k] = 1;
        g_d[k] = pick_data();
        g_t[k] = TW'($urandom);
        g_l[k] = (g_pos[k] >= g_len[k] - 1);
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      vld[k]          = g_v[k];
      dat[k*BW +: BW] = g_d[k];
      tag[k*TW +: TW] = g_t[k];
      lst[k]          = g_l[k];
    end
  endtask

  task automatic set_req(input int k, input bit v, input logic [BW-1:0] d,
                         input logic [TW-1:0] t, input bit l);
    g_v[k] = v; g_d[k] = d; g_t[k] = t; g_l[k] = l;
  endtask

  // One clock: compare at negedge, advance model at posedge, drive new inputs.
  task automatic step();
    bit was_rst;
    @(negedge clk);
    if (!rst) begin
      chk("req_ready", o_req_ready, exp_ready());
      chk("out_valid", o_bf16_valid, m_v);
      if (m_v) begin
        chk("out_data", o_bf16_data, m_data);
        chk("out_src",  o_bf16_src,  m_src);
        chk("out_tag",  o_bf16_tag,  m_tag);
        chk("out_last", o_bf16_last, m_last);
      end
`ifdef MX_CONV_ARB_STATS_EN
      for (int k = 0; k < N; k++) chk("blk_cnt", o_blk_cnt[k*16 +: 16], m_cnt[k]);
`endif
    end
    @(posedge clk);
    was_rst = rst;
    model_update();
    #1;
    if (was_rst) gen_reset();
    if (g_auto) gen_update();
    drive();
    #1;
  endtask

  task automatic do_reset();
    g_auto = 0;
    gen_reset();
    drive();
    rst = 1;
    step();
    rst = 0;
  endtask

  logic [15:0] t1_in  [6] = '{16'h0001, 16'hFFFF, 16'h0181, 16'h01FF, 16'h8000, 16'h0000};
  logic [15:0] t1_out [6] = '{16'h3F80, 16'hBF80, 16'h43C0, 16'h4400, 16'hC700, 16'h0000};
  int srcq [$];
  int rcnt [N];

  initial begin
    gen_reset();
    model_update();

    // Reset state and single-requester conversion table.
    do_reset();
    chk("rst_valid", o_bf16_valid, 0);
    chk("rst_ready", o_req_ready, 0);
    chk("rst_data", o_bf16_data, 0);
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, t1_in[i], TW'(i), 1);
      drive();
      #1;
      chk("t1_ready", o_req_ready, 4'b0001);
      step();
      chk("t1_valid", o_bf16_valid, 1);
      chk("t1_data", o_bf16_data, t1_out[i]);
      chk("t1_src", o_bf16_src, 0);
    end
    set_req(0, 0, '0, '0, 0);
    drive();
    step();
    chk("t1_drain", o_bf16_valid, 0);

    // Requesters 0 and 2 stream 3-element blocks: no interleaving.
    do_reset();
    g_en = 4'b0101; g_prob = 100; g_fixlen = 3; g_auto = 1;
    gen_reset(); m_acc = '0; gen_update(); drive(); #1;
    srcq.delete();
    for (int i = 0; i < 13; i++) begin
      step();
      if (o_bf16_valid) srcq.push_back(int'(o_bf16_src));
    end
    chk("t2_count", srcq.size() >= 12, 1);
    for (int i = 0; i < 12 && i < srcq.size(); i++)
      chk("t2_src", srcq[i], ((i / 3) % 2 == 0) ? 0 : 2);

    // All four requesters with single-element blocks.
    do_reset();
    g_en = 4'b1111; g_prob = 100; g_fixlen = 1; g_auto = 1;
    gen_reset(); m_acc = '0; gen_update(); drive(); #1;
    srcq.delete();
    for (int k = 0; k < N; k++) rcnt[k] = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_bf16_valid) srcq.push_back(int'(o_bf16_src));
      chk("t3_onehot", $onehot(o_req_ready), 1);
      for (int k = 0; k < N; k++) if (o_req_ready[k]) rcnt[k]++;
    end
    for (int i = 0; i < 8 && i < srcq.size(); i++) chk("t3_src", srcq[i], i % 4);
    for (int k = 0; k < N; k++) chk("t3_ready_cnt", rcnt[k], 2);

    // Downstream stall for 5 cycles mid-block.
    do_reset();
    g_en = 4'b0001; g_prob = 100; g_fixlen = 8; g_auto = 1;
    gen_reset(); m_acc = '0; gen_update(); drive(); #1;
    for (int i = 0; i < 3; i++) step();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_ready", o_req_ready, 0);
      chk("t4_stall_valid", o_bf16_valid, 1);
    end
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_resume_valid", o_bf16_valid, 1);
    end

    // Owner drops valid mid-block while requester 1 waits.
    do_reset();
    set_req(0, 1, 16'h0010, 4'h1, 0);
    set_req(1, 1, 16'h0020, 4'h2, 1);
    drive();
    step();
    chk("t5_first_src", o_bf16_src, 0);
    set_req(0, 0, '0, '0, 0);
    drive();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_locked_ready", o_req_ready, 4'b0001);
      step();
    end
    chk("t5_bubble", o_bf16_valid, 0);
    set_req(0, 1, 16'h0030, 4'h3, 1);
    drive();
    step();
    chk("t5_owner_last_src", o_bf16_src, 0);
    chk("t5_owner_last", o_bf16_last, 1);
    chk("t5_next_ready", o_req_ready, 4'b0010);
    step();
    chk("t5_r1_src", o_bf16_src, 1);
    chk("t5_r1_data", o_bf16_data, 16'h4200);

    // Reset mid-block with the output valid.
    do_reset();
    set_req(0, 1, 16'h1234, 4'h5, 0);
    set_req(1, 0, '0, '0, 0);
    drive();
    step();
    chk("t6_pre_valid", o_bf16_valid, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t6_post_valid", o_bf16_valid, 0);
    chk("t6_post_data", o_bf16_data, 0);
    chk("t6_post_tag", o_bf16_tag, 0);
    for (int k = 0; k < N; k++) set_req(k, 1, 16'h0100, TW'(k), 1);
    drive();
    #1;
    chk("t6_first_grant", o_req_ready, 4'b0001);
`ifdef MX_CONV_ARB_STATS_EN
    chk("t6_cnt0", o_blk_cnt, 0);
`endif
    step();

    // Randomized traffic with random backpressure and occasional resets.
    do_reset();
    g_prob = 60; g_fixlen = 0; g_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) g_en = N'($urandom) | 4'b0001;
      rdy = ($urandom % 4 != 0);
      rst = ($urandom % 500 == 0);
      step();
    end
    rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mx_conv_arb.md
# mx_conv_arb

Arbitrated, pipelined front end that shares one combinational fixed-point-to-bf16 converter among `N_REQ` requesters. Requesters stream MX block elements with valid/ready and a block-end marker. Grants are round-robin at block granularity, so one source's block always leaves contiguously. Results are registered into a single output stage with source ID and tag; the block sits between the per-lane fixed-point accumulators and the bf16 writeback path.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `BIT_WIDTH`, 16, two's-complement input width (9..32)
- `TAG_W`, 4, opaque per-element tag width
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; one clock, reset is synchronous and active-high
- `i_req_valid`  in  `N_REQ`  per-requester element valid
- `i_req_data`  in  `N_REQ*BIT_WIDTH`  packed elements, requester k at `[k*BIT_WIDTH +: BIT_WIDTH]`
- `i_req_tag`  in  `N_REQ*TAG_W`  packed tags
- `i_req_last`  in  `N_REQ`  element is last of its block
- `o_req_ready`  out  `N_REQ`  per-requester accept, at most one bit high (one-hot or zero)
- `o_bf16_valid`  out  1  result valid
- `o_bf16_data`  out  16  bf16 result
- `o_bf16_src`  out  `$clog2(N_REQ)`  winning requester index
- `o_bf16_tag`  out  `TAG_W`  tag of converted element
- `o_bf16_last`  out  1  copy of `i_req_last`
- `i_bf16_ready`  in  1  downstream accept

## Operation
- Transfer on requester k: `i_req_valid[k] && o_req_ready[k]`. Output transfer: `o_bf16_valid && i_bf16_ready`.
- Output stage can load when `can_load = !o_bf16_valid || i_bf16_ready`. If `can_load` is 0, every `o_req_ready` bit is 0.
- FSM has two states, IDLE and LOCKED.
  - **IDLE:** round-robin search over the valid requesters, starting at `rr_ptr`.
    - The winner gets `o_req_ready` when `can_load` is 1.
    - Accept with last=1: stay in IDLE, `rr_ptr <= winner+1` (mod `N_REQ`).
    - Accept with last=0: go to LOCKED, `owner <= winner`.
  - **LOCKED:** only `owner` can be granted, and gets `o_req_ready = can_load`. Other requesters are ignored even when valid.
    - Accept with last=1: go to IDLE, `rr_ptr <= owner+1`.
    - Owner deasserting valid mid-block holds the lock. Output bubbles are legal.
- Conversion of each accepted element:
  - Sign is the input MSB; magnitude is the two's-complement negate taken at `BIT_WIDTH` bits.
  - Most-negative input gives magnitude 2^(BIT_WIDTH-1) exactly.
  - Normalize by leading-zero count. Round to 7 fraction bits with round-to-nearest-even (guard = first dropped bit, sticky = OR of the rest).
  - Exponent = msb_index + 127 + carry out of the mantissa round.
  - Zero input gives `0x0000`. There are no denormals, Inf or NaN: the input range cannot produce them.
- Reset at any point, including mid-block:
  - `o_bf16_valid=0`, data/src/tag/last = 0, `o_req_ready=0`.
  - State IDLE, `rr_ptr=0`, `owner=0`.
  - No partial block is resumed.

## Timing
- Latency is 1 cycle: an element accepted at edge t is presented at `o_bf16_*` after edge t.
- Throughput is 1 element/cycle when downstream is always ready, including back-to-back blocks from different sources.
- `o_req_ready` is combinational from `i_req_valid`, FSM state, `o_bf16_valid` and `i_bf16_ready`. There is no combinational path from `i_req_data` to any output.
- While `o_bf16_valid && !i_bf16_ready`, all `o_bf16_*` outputs hold stable.
- Simultaneous drain and load in one cycle: the output register takes the new element; nothing is lost or duplicated.
- The first cycle after reset release can grant requester 0.

## Configuration
- `MX_CONV_ARB_STATS_EN` defined:
  - Adds output `o_blk_cnt`, width `N_REQ*16`.
  - Holds per-requester counts of completed blocks (accepted last=1). Each count saturates at `0xFFFF` and resets to 0.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `mx_conv_pkg`:
  - FSM state enum `arb_state_t` (IDLE, LOCKED).
  - bf16 constants: bias 127, fraction width 7.
  - Function for round-robin next-index.
- Sub-modules:
  - `rr_arb_n` (masked round-robin priority pick: request vector and pointer in, one-hot grant and index out).
  - The team's existing combinational fixed-to-bf16 converter, instantiated once.

## Test plan
- Single requester 0 sends 0x0001, 0xFFFF, 0x0181, 0x01FF, 0x8000, 0x0000, all last=1 -> outputs 0x3F80, 0xBF80, 0x43C0, 0x4400, 0xC700, 0x0000, src=0, 1 cycle each.
- Requesters 0 and 2 both stream 3-element blocks (last on the 3rd element) -> output order is block r0 ×3, r2 ×3, r0 ×3, ... with no interleaving.
- All 4 requesters hold single-element blocks continuously -> src sequence 0,1,2,3,0,…; each `o_req_ready` high exactly once per 4 cycles.
- Downstream holds `i_bf16_ready=0` for 5 cycles mid-block -> outputs stable, all `o_req_ready`=0, no drops; then resumes at 1/cycle.
- Owner drops valid for 3 cycles mid-block while requester 1 is valid -> requester 1 gets no grant until the owner's last element.
- Assert `i_rst` mid-block with output valid -> next cycle `o_bf16_valid=0`, then requester 0 is granted first; with `MX_CONV_ARB_STATS_EN`, counts read 0.
